// File: rtl/inst_rom_arbiter.sv
// Instruction ROM arbiter: shares one ROM between the CPU fetch port and a debug read port.
// CPU has priority, and a run counter guarantees that a waiting DBG request is served.
module inst_rom_arbiter #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MAX_CPU_RUN = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  output logic              cpu_gnt_o,
  output logic              cpu_rvalid_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  input  logic              dbg_req_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  output logic              dbg_gnt_o,
  output logic              dbg_rvalid_o,
  output logic [DATA_W-1:0] dbg_rdata_o,
  output logic              rom_ce_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [DATA_W-1:0] rom_data_i
);

  localparam int unsigned CNT_W = $clog2(MAX_CPU_RUN) + 1;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DBG  = 2'd2
  } owner_e;

  logic [CNT_W-1:0]  run_cnt_q, run_cnt_d;
  logic              rom_ce_q, rom_ce_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  owner_e            owner1_q, owner1_d;
  logic              cpu_rvalid_q, cpu_rvalid_d;
  logic              dbg_rvalid_q, dbg_rvalid_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;

  logic dbg_first_c;
  logic cpu_gnt_c;
  logic dbg_gnt_c;

  // Grant: CPU wins unless DBG has waited MAX_CPU_RUN CPU grants; nothing granted in reset
  always_comb begin
    dbg_first_c = dbg_req_i && (run_cnt_q >= CNT_W'(MAX_CPU_RUN));
    cpu_gnt_c   = rst && cpu_req_i && !dbg_first_c;
    dbg_gnt_c   = rst && dbg_req_i && !cpu_gnt_c;
  end

  // Run counter, stage 1 (ROM address) and stage 2 (response capture)
  always_comb begin
    run_cnt_d    = run_cnt_q;
    rom_ce_d     = 1'b0;
    rom_addr_d   = '0;
    owner1_d     = OWN_NONE;
    cpu_rvalid_d = 1'b0;
    dbg_rvalid_d = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    dbg_rdata_d  = dbg_rdata_q;

    if (!dbg_req_i || dbg_gnt_c) begin
      run_cnt_d = '0;
    end else if (cpu_gnt_c && (run_cnt_q < CNT_W'(MAX_CPU_RUN))) begin
      run_cnt_d = run_cnt_q + CNT_W'(1);
    end

    if (cpu_gnt_c) begin
      rom_ce_d   = 1'b1;
      rom_addr_d = cpu_addr_i;
      owner1_d   = OWN_CPU;
    end else if (dbg_gnt_c) begin
      rom_ce_d   = 1'b1;
      rom_addr_d = dbg_addr_i;
      owner1_d   = OWN_DBG;
    end

    if (owner1_q == OWN_CPU) begin
      cpu_rvalid_d = 1'b1;
      cpu_rdata_d  = rom_data_i;
    end else if (owner1_q == OWN_DBG) begin
      dbg_rvalid_d = 1'b1;
      dbg_rdata_d  = rom_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      run_cnt_q    <= '0;
      rom_ce_q     <= 1'b0;
      rom_addr_q   <= '0;
      owner1_q     <= OWN_NONE;
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      run_cnt_q    <= run_cnt_d;
      rom_ce_q     <= rom_ce_d;
      rom_addr_q   <= rom_addr_d;
      owner1_q     <= owner1_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      dbg_rvalid_q <= dbg_rvalid_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

  assign cpu_gnt_o    = cpu_gnt_c;
  assign dbg_gnt_o    = dbg_gnt_c;
  assign rom_ce_o     = rom_ce_q;
  assign rom_addr_o   = rom_addr_q;
  assign cpu_rvalid_o = cpu_rvalid_q;
  assign cpu_rdata_o  = cpu_rdata_q;
  assign dbg_rvalid_o = dbg_rvalid_q;
  assign dbg_rdata_o  = dbg_rdata_q;

endmodule
